float_denormalizer: RTL and testbench



---
 rtl/float_pkg.sv | 20 ++
 rtl/shift_step.sv | 23 ++
 rtl/float_denormalizer.sv | 115 +++++++++++
 tb/tb_float_denormalizer.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/float_pkg.sv
// Shared constants and types for the floating-format datapath blocks.
// Mantissa/exponent widths, denormalizer FSM states, saturation helper.
// Pure definitions; no timing or flow control.
package float_pkg;

  localparam int MANT_W = 15;
  localparam int EXP_W  = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Largest positive two's-complement value of width w (w in 2..64), right-aligned.
  function automatic logic [63:0] sat_max(input int w);
    return 64'h7FFF_FFFF_FFFF_FFFF >> (64 - w);
  endfunction

endpackage

// File: rtl/shift_step.sv
// One-bit shift of a W-bit signed value: logical left or arithmetic right.
// Combinational, zero latency.
// No flow control; the caller decides when to register the result.
module shift_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_dat,
  input  logic         i_left,
  output logic [W-1:0] o_dat,
  output logic         o_ovf
);

  // Left shift flags overflow when the bit leaving the MSB differs from the new MSB.
  always_comb begin
    o_dat = {i_dat[W-1], i_dat[W-1:1]};
    o_ovf = 1'b0;
    if (i_left) begin
      o_dat = {i_dat[W-2:0], 1'b0};
      o_ovf = i_dat[W-1] ^ i_dat[W-2];
    end
  end

endmodule

// File: rtl/float_denormalizer.sv
// Converts mantissa x 2^exponent to a saturating signed OUT_W-bit integer.
// Latency |exp|+1 cycles from acceptance to the oValid pulse.
// iReady only in IDLE; one operand in flight, iValid elsewhere is ignored.
module float_denormalizer
  import float_pkg::*;
#(
  parameter int OUT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iValid,
  input  logic [MANT_W-1:0] iMant,
  input  logic [EXP_W-1:0]  iExp,
  output logic              iReady,
  output logic              oValid,
  output logic [OUT_W-1:0]  oFixed,
  output logic              oOvf
);

  localparam logic [63:0]      SAT64   = sat_max(OUT_W);
  localparam logic [OUT_W-1:0] SAT_POS = SAT64[OUT_W-1:0];
  localparam logic [OUT_W-1:0] SAT_NEG = ~SAT_POS;

  state_t             r_state;
  state_t             w_next_state;
  logic [OUT_W-1:0]   r_acc;
  logic [EXP_W-1:0]   r_cnt;
  logic               r_left;
  logic               r_ovf;
  logic               r_neg;
  logic               r_valid;
  logic [OUT_W-1:0]   r_fixed;
  logic               r_oovf;

  logic               w_accept;
  logic [EXP_W-1:0]   w_abs_exp;
  logic [OUT_W-1:0]   w_mant_ext;
  logic [OUT_W-1:0]   w_step_dat;
  logic               w_step_ovf;

  // |iExp| fits in EXP_W bits unsigned: -16 negates to 5'b10000 = 16.
  assign w_abs_exp  = iExp[EXP_W-1] ? (~iExp + EXP_W'(1)) : iExp;
  assign w_mant_ext = {{(OUT_W-MANT_W){iMant[MANT_W-1]}}, iMant};

  shift_step #(.W(OUT_W)) u_shift_step (
    .i_dat  (r_acc),
    .i_left (r_left),
    .o_dat  (w_step_dat),
    .o_ovf  (w_step_ovf)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state and handshake decode; the last SHIFT is the one with count 1.
  always_comb begin
    w_next_state = r_state;
    iReady       = 1'b0;
    w_accept     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        iReady   = 1'b1;
        w_accept = iValid;
        if (iValid) w_next_state = (iExp == '0) ? ST_DONE : ST_SHIFT;
      end
      ST_SHIFT: if (r_cnt == EXP_W'(1)) w_next_state = ST_DONE;
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Datapath: load on acceptance, one shift per SHIFT cycle with sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_cnt  <= '0;
      r_left <= 1'b0;
      r_ovf  <= 1'b0;
      r_neg  <= 1'b0;
    end else if (w_accept) begin
      r_acc  <= w_mant_ext;
      r_cnt  <= w_abs_exp;
      r_left <= ~iExp[EXP_W-1];
      r_ovf  <= 1'b0;
      r_neg  <= iMant[MANT_W-1];
    end else if (r_state == ST_SHIFT) begin
      r_acc  <= w_step_dat;
      r_cnt  <= r_cnt - EXP_W'(1);
      r_ovf  <= r_ovf | w_step_ovf;
    end
  end

  // Result registers: capture (saturated) value on DONE, hold until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_fixed <= '0;
      r_oovf  <= 1'b0;
    end else begin
      r_valid <= (r_state == ST_DONE);
      if (r_state == ST_DONE) begin
        r_fixed <= r_ovf ? (r_neg ? SAT_NEG : SAT_POS) : r_acc;
        r_oovf  <= r_ovf;
      end
    end
  end

  assign oValid = r_valid;
  assign oFixed = r_fixed;
  assign oOvf   = r_oovf;

endmodule

// File: tb/tb_float_denormalizer.sv
module tb_float_denormalizer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        v32 = 1'b0, v16 = 1'b0;
  logic [14:0] m32 = '0, m16 = '0;
  logic [4:0]  e32 = '0, e16 = '0;
  logic        rdy32, rdy16, ov32, ov16, of32, of16;
  logic [31:0] fx32;
  logic [15:0] fx16;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  float_denormalizer #(.OUT_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .iValid(v32), .iMant(m32), .iExp(e32),
    .iReady(rdy32), .oValid(ov32), .oFixed(fx32), .oOvf(of32)
  );

  float_denormalizer #(.OUT_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .iValid(v16), .iMant(m16), .iExp(e16),
    .iReady(rdy16), .oValid(ov16), .oFixed(fx16), .oOvf(of16)
  );

  typedef struct {
    bit          w16;
    logic [14:0] m;
    logic [4:0]  e;
    logic [63:0] xf;
    bit          xo;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Reference: exact value m*2^e (floor for negative e), then clamp to the output range.
  function automatic void model(input int w, input logic [14:0] m, input logic [4:0] e,
                                output logic [63:0] xf, output bit xo);
    longint v, mx, mn;
    int ei;
    v  = longint'($signed(m));
    ei = int'($signed(e));
    if (ei >= 0) v = v * (longint'(1) << ei);
    else         v = v >>> (-ei);
    mx = (longint'(1) << (w - 1)) - 1;
    mn = -mx - 1;
    xo = 1'b0;
    if (v > mx)      begin v = mx; xo = 1'b1; end
    else if (v < mn) begin v = mn; xo = 1'b1; end
    xf = v;
  endfunction

  // Call at posedge+1. Returns at posedge+1 of the oValid cycle.
  task automatic run_op(input bit w16, input logic [14:0] m, input logic [4:0] e,
                        input logic [63:0] xf, input bit xo, input string nm);
    int lat, to, ae;
    bit seen;
    logic [63:0] got_f, req_f;
    ae = int'($signed(e));
    if (ae < 0) ae = -ae;
    to = 0;
    while (!(w16 ? rdy16 : rdy32) && to < 40) begin
      @(posedge clk); #1; to++;
    end
    check({nm, " ready"}, w16 ? rdy16 : rdy32, 64'd1);
    if (w16) begin v16 = 1'b1; m16 = m; e16 = e; end
    else     begin v32 = 1'b1; m32 = m; e32 = e; end
    @(posedge clk); #1;
    v16 = 1'b0; v32 = 1'b0;
    check({nm, " ready_drop"}, w16 ? rdy16 : rdy32, 64'd0);
    lat = 0; seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clk); #1; lat++;
      seen = w16 ? ov16 : ov32;
    end
    check({nm, " latency"}, 64'(lat), 64'(ae + 1));
    got_f = w16 ? {48'b0, fx16} : {32'b0, fx32};
    req_f = w16 ? {48'b0, xf[15:0]} : {32'b0, xf[31:0]};
    check({nm, " fixed"}, got_f, req_f);
    check({nm, " ovf"}, w16 ? of16 : of32, {63'b0, xo});
  endtask

  initial begin
    logic [63:0] xf;
    bit xo, sel;
    logic [14:0] rm;
    logic [4:0] re;
    int npulse;

    tbl[0]  = '{1'b0, 15'h0010, 5'h01, 64'h0000_0020, 1'b0};
    tbl[1]  = '{1'b0, 15'h0030, 5'h00, 64'h0000_0030, 1'b0};
    tbl[2]  = '{1'b0, 15'h7FFD, 5'h1F, 64'hFFFF_FFFE, 1'b0};
    tbl[3]  = '{1'b0, 15'h0010, 5'h10, 64'h0000_0000, 1'b0};
    tbl[4]  = '{1'b0, 15'h3FFF, 5'h0F, 64'h1FFF_8000, 1'b0};
    tbl[5]  = '{1'b0, 15'h0000, 5'h0F, 64'h0000_0000, 1'b0};
    tbl[6]  = '{1'b0, 15'h4000, 5'h0F, 64'hE000_0000, 1'b0};
    tbl[7]  = '{1'b0, 15'h7FFF, 5'h10, 64'hFFFF_FFFF, 1'b0};
    tbl[8]  = '{1'b1, 15'h0100, 5'h08, 64'h7FFF, 1'b1};
    tbl[9]  = '{1'b1, 15'h7F00, 5'h08, 64'h8000, 1'b1};
    tbl[10] = '{1'b1, 15'h0001, 5'h0F, 64'h7FFF, 1'b1};
    tbl[11] = '{1'b1, 15'h7FFF, 5'h0F, 64'h8000, 1'b0};
    tbl[12] = '{1'b1, 15'h3FFF, 5'h01, 64'h7FFE, 1'b0};

    // Reset values while held in reset.
    #12;
    check("rst rdy32", rdy32, 64'd1);
    check("rst ov32",  ov32,  64'd0);
    check("rst fx32",  fx32,  64'd0);
    check("rst of32",  of32,  64'd0);
    check("rst rdy16", rdy16, 64'd1);
    check("rst fx16",  fx16,  64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++)
      run_op(tbl[i].w16, tbl[i].m, tbl[i].e, tbl[i].xf, tbl[i].xo, $sformatf("vec%0d", i));

    // Back-to-back: second operand accepted in the oValid cycle of the first.
    v32 = 1'b1; m32 = 15'h0030; e32 = 5'h00;
    @(posedge clk); #1;
    check("b2b ready_drop", rdy32, 64'd0);
    m32 = 15'h0010; e32 = 5'h01;
    @(posedge clk); #1;
    check("b2b valid_a", ov32, 64'd1);
    check("b2b fixed_a", fx32, 64'h30);
    check("b2b ready_a", rdy32, 64'd1);
    @(posedge clk); #1;
    check("b2b accept_b", rdy32, 64'd0);
    check("b2b valid_pulse", ov32, 64'd0);
    v32 = 1'b0;
    @(posedge clk); #1;
    check("b2b b_early", ov32, 64'd0);
    @(posedge clk); #1;
    check("b2b valid_b", ov32, 64'd1);
    check("b2b fixed_b", fx32, 64'h20);

    // Reset during the 3rd SHIFT cycle of an exponent-10 operation.
    v32 = 1'b1; m32 = 15'h0005; e32 = 5'd10;
    @(posedge clk); #1;
    v32 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    check("mrst fixed", fx32, 64'd0);
    check("mrst valid", ov32, 64'd0);
    check("mrst ovf",   of32, 64'd0);
    check("mrst ready", rdy32, 64'd1);
    #1 rst_n = 1'b1;
    npulse = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (ov32) npulse++;
    end
    check("mrst no_valid", 64'(npulse), 64'd0);
    run_op(1'b0, 15'h0005, 5'd10, 64'h1400, 1'b0, "mrst next");

    // Randomized operands against the reference model.
    for (int i = 0; i < 200; i++) begin
      sel = 1'($urandom_range(0, 1));
      rm  = 15'($urandom);
      re  = 5'($urandom);
      if (i % 17 == 0) rm = '0;
      model(sel ? 16 : 32, rm, re, xf, xo);
      run_op(sel, rm, re, xf, xo, $sformatf("rnd%0d m=%0h e=%0h w16=%0d", i, rm, re, sel));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
